// File: rtl/multi_pulser.sv
// -----------------------------------------------------------------------------
// multi_pulser
//
// A bank of CHANNELS independent pulse generators. Each channel contains:
//   - a strobe counter, which produces a periodic start event in periodic mode;
//   - a shot counter, which stretches each start event into a pulse that is
//     duration+1 cycles wide.
// A start event can come from the channel's strobe or from its trigger input.
// A start that arrives while a pulse is already running restarts that pulse.
//
// Build option:
//   MULTI_PULSER_CHAIN_EN - when this macro is defined, fired[i] is an extra
//                           start source for channel i+1. The channels then
//                           form a pulse sequencer. When it is undefined, the
//                           channels are fully independent.
//
// Ports:
//   clock        sole clock; all logic runs on its rising edge
//   reset        synchronous, active-high; has priority over every other input
//   enable       per-channel strobe counter enable
//   trigger      per-channel one-shot trigger, level sampled every cycle
//   cfg_valid    configuration write strobe
//   cfg_channel  channel addressed by the write (values >= CHANNELS are ignored)
//   cfg_period   new period for the addressed channel
//   cfg_duration new duration for the addressed channel
//   cfg_mode     new mode: 0 = periodic, 1 = one-shot (trigger only)
//   pulse        per-channel registered pulse output
//   fired        per-channel flag, high for one cycle in the last pulse cycle
//   any_active   OR of all pulse bits
// -----------------------------------------------------------------------------
module multi_pulser #(
    parameter int CHANNELS         = 4,
    parameter int COUNT_WIDTH      = 32,
    parameter int DEFAULT_PERIOD   = 27000000,
    parameter int DEFAULT_DURATION = 2700000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [CHANNELS-1:0]    enable,
    input  logic [CHANNELS-1:0]    trigger,
    input  logic                   cfg_valid,
    input  logic [3:0]             cfg_channel,
    input  logic [COUNT_WIDTH-1:0] cfg_period,
    input  logic [COUNT_WIDTH-1:0] cfg_duration,
    input  logic                   cfg_mode,
    output logic [CHANNELS-1:0]    pulse,
    output logic [CHANNELS-1:0]    fired,
    output logic                   any_active
);

    localparam logic [COUNT_WIDTH-1:0] RST_PERIOD   = COUNT_WIDTH'(DEFAULT_PERIOD);
    localparam logic [COUNT_WIDTH-1:0] RST_DURATION = COUNT_WIDTH'(DEFAULT_DURATION);
    localparam logic                   MODE_PERIODIC = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [COUNT_WIDTH-1:0] period_reg;
            logic [COUNT_WIDTH-1:0] duration_reg;
            logic [COUNT_WIDTH-1:0] strobe_cnt_reg;
            logic [COUNT_WIDTH-1:0] shot_cnt_reg;
            logic                   mode_reg;
            logic                   pulse_reg;
            logic                   cfg_hit;
            logic                   count_en;
            logic                   strobe;
            logic                   shot_done;
            logic                   start;

            // The address compare is exact, so an index >= CHANNELS never
            // matches any channel.
            assign cfg_hit  = cfg_valid && (cfg_channel == 4'(gi));
            assign count_en = enable[gi] && (mode_reg == MODE_PERIODIC) &&
                              (period_reg != '0);
            assign strobe   = count_en && (strobe_cnt_reg == period_reg);

            // fired is gated by reset, so a pulse that reset cuts short never
            // reports completion.
            assign shot_done = pulse_reg && (shot_cnt_reg == duration_reg) && !reset;

`ifdef MULTI_PULSER_CHAIN_EN
            if (gi > 0) begin : g_chain
                assign start = strobe || trigger[gi] || fired[gi-1];
            end else begin : g_head
                assign start = strobe || trigger[gi];
            end
`else
            assign start = strobe || trigger[gi];
`endif

            always_ff @(posedge clock) begin
                if (reset) begin
                    period_reg     <= RST_PERIOD;
                    duration_reg   <= RST_DURATION;
                    mode_reg       <= MODE_PERIODIC;
                    strobe_cnt_reg <= '0;
                    shot_cnt_reg   <= '0;
                    pulse_reg      <= 1'b0;
                end else begin
                    // Strobe counter. A configuration write restarts the phase.
                    // After a strobe the counter reloads 1, which gives exactly
                    // one strobe every 'period' enabled cycles.
                    if (cfg_hit) begin
                        period_reg     <= cfg_period;
                        duration_reg   <= cfg_duration;
                        mode_reg       <= cfg_mode;
                        strobe_cnt_reg <= '0;
                    end else if (strobe) begin
                        strobe_cnt_reg <= COUNT_WIDTH'(1);
                    end else if (count_en) begin
                        strobe_cnt_reg <= strobe_cnt_reg + 1'b1;
                    end

                    // Shot counter. A start, even one in the fired cycle,
                    // restarts the pulse and keeps it high.
                    if (start) begin
                        pulse_reg    <= 1'b1;
                        shot_cnt_reg <= '0;
                    end else if (pulse_reg) begin
                        shot_cnt_reg <= shot_cnt_reg + 1'b1;
                        if (shot_done) begin
                            pulse_reg <= 1'b0;
                        end
                    end
                end
            end

            assign pulse[gi] = pulse_reg;
            assign fired[gi] = shot_done;
        end
    endgenerate

    assign any_active = |pulse;

endmodule

// File: tb/tb_multi_pulser.sv
// -----------------------------------------------------------------------------
// tb_multi_pulser
//
// Testbench for multi_pulser with CHANNELS=4 and COUNT_WIDTH=8.
//
// The bench has two checking paths:
//   - Scoreboard: every cycle, a behavioural model computes the expected
//     pulse, fired and any_active values and pushes them into a queue. A
//     separate monitor process pops each entry on the falling edge and
//     compares it with the DUT outputs.
//   - Directed checks: the stimulus thread compares selected cycles against
//     constant timelines written out for the documented scenarios.
//
// The model tracks each pulse by its start cycle. The expected shot count is
// derived from elapsed time rather than from a mirrored counter.
// -----------------------------------------------------------------------------
module tb_multi_pulser;

    localparam int CH = 4;
    localparam int CW = 8;
    localparam int DEF_PER = 10;
    localparam int DEF_DUR = 2;

    logic          clock;
    logic          reset;
    logic [CH-1:0] enable;
    logic [CH-1:0] trigger;
    logic          cfg_valid;
    logic [3:0]    cfg_channel;
    logic [CW-1:0] cfg_period;
    logic [CW-1:0] cfg_duration;
    logic          cfg_mode;
    logic [CH-1:0] pulse;
    logic [CH-1:0] fired;
    logic          any_active;

    multi_pulser #(
        .CHANNELS        (CH),
        .COUNT_WIDTH     (CW),
        .DEFAULT_PERIOD  (DEF_PER),
        .DEFAULT_DURATION(DEF_DUR)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .trigger     (trigger),
        .cfg_valid   (cfg_valid),
        .cfg_channel (cfg_channel),
        .cfg_period  (cfg_period),
        .cfg_duration(cfg_duration),
        .cfg_mode    (cfg_mode),
        .pulse       (pulse),
        .fired       (fired),
        .any_active  (any_active)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input int cy, input logic [31:0] got,
                         input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cy, got, want);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        int         cy;
        logic [3:0] p;
        logic [3:0] f;
        logic       a;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int         m_per[CH];
    int         m_dur[CH];
    int         m_scnt[CH];
    int         m_start[CH];
    bit         m_mode[CH];
    bit         m_act[CH];
    bit         m_strobe[CH];
    bit         m_go[CH];
    bit         m_run;
    bit         model_valid = 0;
    int         mc;
    logic [3:0] m_p;
    logic [3:0] m_f;

    always @(posedge clock) begin
        #2;
        mc = cyc;
        for (int ch = 0; ch < CH; ch++) begin
            m_p[ch] = m_act[ch];
            // The pulse ends in the cycle where its elapsed length (mod 2^CW)
            // equals the duration in force.
            m_f[ch] = m_act[ch] && (((mc - m_start[ch] - 1) % 256) == m_dur[ch]) && !reset;
        end
        for (int ch = 0; ch < CH; ch++) begin
            m_strobe[ch] = enable[ch] && !m_mode[ch] && (m_per[ch] != 0) &&
                           (m_scnt[ch] == m_per[ch]);
            m_go[ch]     = m_strobe[ch] || trigger[ch];
        end
`ifdef MULTI_PULSER_CHAIN_EN
        for (int ch = 1; ch < CH; ch++) m_go[ch] = m_go[ch] || m_f[ch-1];
`endif
        if (model_valid) sb_q.push_back('{mc, m_p, m_f, |m_p});

        if (reset) begin
            for (int ch = 0; ch < CH; ch++) begin
                m_per[ch]  = DEF_PER;
                m_dur[ch]  = DEF_DUR;
                m_mode[ch] = 1'b0;
                m_scnt[ch] = 0;
                m_act[ch]  = 1'b0;
            end
            model_valid = 1;
        end else begin
            for (int ch = 0; ch < CH; ch++) begin
                m_run = enable[ch] && !m_mode[ch] && (m_per[ch] != 0);
                if (cfg_valid && (int'(cfg_channel) == ch)) begin
                    m_per[ch]  = int'(cfg_period);
                    m_dur[ch]  = int'(cfg_duration);
                    m_mode[ch] = cfg_mode;
                    m_scnt[ch] = 0;
                end else if (m_strobe[ch]) begin
                    m_scnt[ch] = 1;
                end else if (m_run) begin
                    m_scnt[ch] = (m_scnt[ch] + 1) % 256;
                end
                if (m_go[ch]) begin
                    m_act[ch]   = 1'b1;
                    m_start[ch] = mc;
                end else if (m_f[ch]) begin
                    m_act[ch] = 1'b0;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check("sb_pulse", mon_e.cy, 32'(pulse), 32'(mon_e.p));
            check("sb_fired", mon_e.cy, 32'(fired), 32'(mon_e.f));
            check("sb_any_active", mon_e.cy, 32'(any_active), 32'(mon_e.a));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic cfg(input int ch, input int per, input int dur, input bit mode);
        cfg_valid    = 1'b1;
        cfg_channel  = 4'(ch);
        cfg_period   = CW'(per);
        cfg_duration = CW'(dur);
        cfg_mode     = mode;
        $display("cycle %0d cfg ch=%0d period=%0d duration=%0d mode=%0d",
                 cyc, ch, per, dur, mode);
        next_cycle();
        cfg_valid = 1'b0;
    endtask

    // Channel 1 one-shot timeline. Trigger at k=0, an optional second trigger
    // at k=t2, and an optional reset at k=rst_at. The bench expects pulse high
    // for k=1..p_hi and fired only at k=f_at.
    task automatic shot_test(input string nm, input int t2, input int rst_at,
                             input int p_hi, input int f_at);
        for (int k = 0; k <= 8; k++) begin
            trigger    = '0;
            trigger[1] = (k == 0) || (k == t2);
            reset      = (k == rst_at);
            $display("cycle %0d %s k=%0d trigger1=%0b reset=%0b", cyc, nm, k, trigger[1], reset);
            #5;
            check({nm, "_pulse1"}, cyc, 32'(pulse[1]), 32'((k >= 1) && (k <= p_hi)));
            check({nm, "_fired1"}, cyc, 32'(fired[1]), 32'(k == f_at));
            next_cycle();
        end
        trigger = '0;
        reset   = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        enable       = '0;
        trigger      = '0;
        cfg_valid    = 1'b0;
        cfg_channel  = '0;
        cfg_period   = '0;
        cfg_duration = '0;
        cfg_mode     = 1'b0;
        next_cycle();
        next_cycle();
        #5;
        check("reset_pulse", cyc, 32'(pulse), 32'(0));
        check("reset_fired", cyc, 32'(fired), 32'(0));
        check("reset_any_active", cyc, 32'(any_active), 32'(0));
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // Channel 0, periodic mode, period 5, duration 2.
        enable[0] = 1'b1;
        cfg(0, 5, 2, 1'b0);
        for (int k = 1; k <= 17; k++) begin
            #5;
            check("periodic_pulse0", cyc, 32'(pulse[0]),
                  32'(((k >= 7) && (k <= 9)) || ((k >= 12) && (k <= 14)) || (k == 17)));
            check("periodic_fired0", cyc, 32'(fired[0]), 32'((k == 9) || (k == 14)));
            next_cycle();
        end
        enable[0] = 1'b0;
        repeat (6) next_cycle();

        // Channel 1, one-shot mode, duration 3. enable[1] must have no effect.
        cfg(1, 4, 3, 1'b1);
        enable[1] = 1'b1;
        repeat (3) next_cycle();
        shot_test("oneshot", -1, -1, 4, 4);
        shot_test("retrigger", 2, -1, 6, 6);
        shot_test("reset_mid", -1, 2, 2, -1);
        enable = '0;
        repeat (3) next_cycle();

`ifdef MULTI_PULSER_CHAIN_EN
        cfg(0, 3, 1, 1'b1);
        cfg(1, 3, 1, 1'b1);
        repeat (2) next_cycle();
        for (int k = 0; k <= 6; k++) begin
            trigger[0] = (k == 0);
            #5;
            check("chain_pulse0", cyc, 32'(pulse[0]), 32'((k >= 1) && (k <= 2)));
            check("chain_fired0", cyc, 32'(fired[0]), 32'(k == 2));
            check("chain_pulse1", cyc, 32'(pulse[1]), 32'((k >= 3) && (k <= 4)));
            check("chain_fired1", cyc, 32'(fired[1]), 32'(k == 4));
            next_cycle();
        end
        trigger = '0;
`endif

        // An out-of-range write must not disturb channel 3, which keeps its
        // default periodic configuration. A channel with period 0 never pulses.
        enable[3] = 1'b1;
        cfg(7, 1, 0, 1'b0);
        cfg(2, 0, 1, 1'b0);
        enable[2] = 1'b1;
        for (int k = 0; k < 300; k++) begin
            #5;
            check("period0_pulse2", cyc, 32'(pulse[2]), 32'(0));
            next_cycle();
        end

        // Randomised traffic, checked by the scoreboard.
        for (int k = 0; k < 3000; k++) begin
            enable = 4'($urandom);
            for (int ch = 0; ch < CH; ch++) trigger[ch] = ($urandom_range(0, 24) == 0);
            reset = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 19) == 0) begin
                cfg_valid    = 1'b1;
                cfg_channel  = 4'($urandom_range(0, 9));
                cfg_period   = CW'($urandom_range(0, 12));
                cfg_duration = ($urandom_range(0, 30) == 0) ? CW'(255) : CW'($urandom_range(0, 6));
                cfg_mode     = ($urandom_range(0, 3) == 0);
                $display("cycle %0d cfg ch=%0d period=%0d duration=%0d mode=%0d reset=%0b",
                         cyc, cfg_channel, cfg_period, cfg_duration, cfg_mode, reset);
            end else begin
                cfg_valid = 1'b0;
            end
            next_cycle();
        end
        enable    = '0;
        trigger   = '0;
        reset     = 1'b0;
        cfg_valid = 1'b0;
        next_cycle();
        #10;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
